// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for the bit-serial subtractor.
//   start, a, b   : request and operands, driven by the requester (master)
//   busy, done    : status from the subtractor (slave)
//   out           : registered result, valid from the done cycle onward
//   borrow_out, zero, ovf : result flags, present only when SERIAL_SUB_FLAGS_EN is defined
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             borrow_out;
    logic             zero;
    logic             ovf;
`endif

    modport master (
        output start, a, b,
`ifdef SERIAL_SUB_FLAGS_EN
        input  borrow_out, zero, ovf,
`endif
        input  busy, done, out
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_SUB_FLAGS_EN
        output borrow_out, zero, ovf,
`endif
        output busy, done, out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: out = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; drops any operation in flight
//   bus   : serial_subtractor_if.slave (start/a/b in, busy/done/out out)
// Optional feature macro SERIAL_SUB_FLAGS_EN adds registered borrow_out, zero and ovf
// flags, updated together with out.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] acc_q, acc_n;
    logic [WIDTH-1:0] out_q, out_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             borrow_q, borrow_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    // One full-subtractor slice on the bit selected by cnt.
    logic bit_a_c, bit_b_c, diff_c, borrow_c;
    assign bit_a_c  = a_q[cnt_q];
    assign bit_b_c  = b_q[cnt_q];
    assign diff_c   = bit_a_c ^ bit_b_c ^ borrow_q;
    assign borrow_c = (~bit_a_c & bit_b_c) | (~(bit_a_c ^ bit_b_c) & borrow_q);

`ifdef SERIAL_SUB_FLAGS_EN
    logic borrow_out_q, borrow_out_n;
    logic zero_q, zero_n;
    logic ovf_q, ovf_n;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        acc_n    = acc_q;
        out_n    = out_q;
        cnt_n    = cnt_q;
        borrow_n = borrow_q;
        busy_n   = 1'b0;
        done_n   = 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
        borrow_out_n = borrow_out_q;
        zero_n       = zero_q;
        ovf_n        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n  = SHIFT;
                    a_n      = bus.a;
                    b_n      = bus.b;
                    borrow_n = 1'b0;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
                acc_n    = {diff_c, acc_q[WIDTH-1:1]};
                borrow_n = borrow_c;
                cnt_n    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    out_n   = acc_n;
`ifdef SERIAL_SUB_FLAGS_EN
                    borrow_out_n = borrow_c;
                    zero_n       = (acc_n == '0);
                    ovf_n        = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_n[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    busy_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            acc_q    <= acc_n;
            out_q    <= out_n;
            cnt_q    <= cnt_n;
            borrow_q <= borrow_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
`ifdef SERIAL_SUB_FLAGS_EN
            borrow_out_q <= borrow_out_n;
            zero_q       <= zero_n;
            ovf_q        <= ovf_n;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
`ifdef SERIAL_SUB_FLAGS_EN
    assign bus.borrow_out = borrow_out_q;
    assign bus.zero       = zero_q;
    assign bus.ovf        = ovf_q;
`endif
endmodule
